// File: rtl/dcache_mem_pkg.sv
// Shared definitions for the Dcache memory-side responder.
// Holds the default line geometry, the FSM state encoding and the latched
// request payload.
package dcache_mem_pkg;

    localparam int unsigned OFFSET_WIDTH = 2;
    localparam int unsigned LINE_WORDS   = 1 << OFFSET_WIDTH;
    localparam int unsigned WORD_W       = 32;
    localparam logic [1:0]  SIZE_WORD    = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Request fields captured at acceptance.
    typedef struct packed {
        logic        wr;
        logic        suc;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dcache_mem_responder_if.sv
// Dcache mem port plus the word bus, bundled for the responder.
//  slave  : responder view (takes Dcache request and bus replies, drives the rest)
//  master : environment view (Dcache side and memory side)
interface dcache_mem_responder_if #(
    parameter int unsigned offset_width = dcache_mem_pkg::OFFSET_WIDTH
);
    localparam int unsigned LINE_BITS = 32 << offset_width;

    logic                 dcache_mem_req;
    logic                 dcache_mem_wr;
    logic                 dcache_mem_SUC;
    logic [1:0]           dcache_mem_size;
    logic [3:0]           dcache_mem_wstrb;
    logic [31:0]          addr_dcache_mem;
    logic [31:0]          dout_dcache_mem;
    logic                 mem_dcache_addrOK;
    logic                 mem_dcache_dataOK;
    logic [LINE_BITS-1:0] din_mem_dcache;

    logic                 bus_req;
    logic                 bus_we;
    logic [31:0]          bus_addr;
    logic [31:0]          bus_wdata;
    logic [3:0]           bus_wstrb;
    logic [1:0]           bus_size;
    logic                 bus_gnt;
    logic                 bus_rvalid;
    logic [31:0]          bus_rdata;

    modport slave (
        input  dcache_mem_req, dcache_mem_wr, dcache_mem_SUC, dcache_mem_size,
               dcache_mem_wstrb, addr_dcache_mem, dout_dcache_mem,
               bus_gnt, bus_rvalid, bus_rdata,
        output mem_dcache_addrOK, mem_dcache_dataOK, din_mem_dcache,
               bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_size
    );

    modport master (
        output dcache_mem_req, dcache_mem_wr, dcache_mem_SUC, dcache_mem_size,
               dcache_mem_wstrb, addr_dcache_mem, dout_dcache_mem,
               bus_gnt, bus_rvalid, bus_rdata,
        input  mem_dcache_addrOK, mem_dcache_dataOK, din_mem_dcache,
               bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_size
    );

endinterface

// File: rtl/dcache_line_buf.sv
// Line assembly buffer: LINE_WORDS x 32 registers with per-word write,
// whole-line clear and a flat line output (word i at [32i+31:32i]).
//  clk, rst : clock, async active-high reset (clears the line)
//  clr      : clear every word (takes priority over we)
//  we/widx/wdata : write one word
//  line     : registered flat line
module dcache_line_buf
    import dcache_mem_pkg::*;
#(
    parameter int unsigned offset_width = OFFSET_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clr,
    input  logic                                   we,
    input  logic [offset_width-1:0]                widx,
    input  logic [WORD_W-1:0]                      wdata,
    output logic [WORD_W*(1 << offset_width)-1:0]  line
);
    localparam int unsigned LINE_W = 1 << offset_width;

    logic [WORD_W-1:0] word_q [LINE_W];

    // Word storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LINE_W; i++) word_q[i] <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < LINE_W; i++) word_q[i] <= '0;
        end else if (we) begin
            word_q[widx] <= wdata;
        end
    end

    // Flatten into the line vector.
    for (genvar i = 0; i < LINE_W; i++) begin : g_word
        assign line[WORD_W*i +: WORD_W] = word_q[i];
    end

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the L1 Dcache mem port. Takes one request at a
// time (line refill, uncached word read or word write), turns it into word
// transactions on an in-order req/gnt/rvalid bus and returns addrOK/dataOK
// and the assembled line.
//  clk, rst : clock, async active-high reset
//  dc       : Dcache request/response and word-bus signals (slave view)
module dcache_mem_responder
    import dcache_mem_pkg::*;
#(
    parameter int unsigned offset_width = OFFSET_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    dcache_mem_responder_if.slave  dc
);
    localparam int unsigned LINE_W = 1 << offset_width;
    localparam int unsigned CNT_W  = offset_width + 1;

    state_e                    state_q, state_d;
    req_t                      req_q;
    logic [CNT_W-1:0]          ic_q, rc_q, total_c;
    logic [31:0]               base_c;
    logic                      accept_c, ic_inc_c, rc_inc_c;
    logic [WORD_W*LINE_W-1:0]  line_c;

    // Uncached reads fetch one aligned word; refills fetch the whole aligned line.
    assign total_c = req_q.suc ? CNT_W'(1) : CNT_W'(LINE_W);
    assign base_c  = req_q.suc ? (req_q.addr & ~32'd3)
                               : (req_q.addr & ~(32'(LINE_W * 4) - 32'd1));

    // Next state, handshake and bus drive.
    always_comb begin
        state_d              = state_q;
        accept_c             = 1'b0;
        ic_inc_c             = 1'b0;
        rc_inc_c             = 1'b0;
        dc.mem_dcache_addrOK = 1'b0;
        dc.mem_dcache_dataOK = 1'b0;
        dc.bus_req           = 1'b0;
        dc.bus_we            = 1'b0;
        dc.bus_addr          = '0;
        dc.bus_wdata         = '0;
        dc.bus_wstrb         = '0;
        dc.bus_size          = '0;
        case (state_q)
            IDLE: begin
                if (dc.dcache_mem_req) begin
                    accept_c             = 1'b1;
                    dc.mem_dcache_addrOK = 1'b1;
                    state_d              = dc.dcache_mem_wr ? WR : RD;
                end
            end
            WR: begin
                dc.bus_req   = 1'b1;
                dc.bus_we    = 1'b1;
                dc.bus_addr  = req_q.addr;
                dc.bus_wdata = req_q.wdata;
                dc.bus_wstrb = req_q.wstrb;
                dc.bus_size  = req_q.size;
                if (dc.bus_gnt) state_d = DONE;
            end
            RD: begin
                // Issue and return sides run independently; both may step together.
                if (ic_q < total_c) begin
                    dc.bus_req  = 1'b1;
                    dc.bus_addr = base_c + (32'(ic_q) << 2);
                    dc.bus_size = req_q.suc ? req_q.size : SIZE_WORD;
                    ic_inc_c    = dc.bus_gnt;
                end
                if (dc.bus_rvalid && (rc_q < total_c)) begin
                    rc_inc_c = 1'b1;
                    if ((rc_q + CNT_W'(1)) == total_c) state_d = DONE;
                end
            end
            DONE: begin
                dc.mem_dcache_dataOK = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request latch and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            ic_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept_c) begin
                req_q <= '{wr:    dc.dcache_mem_wr,
                           suc:   dc.dcache_mem_SUC,
                           size:  dc.dcache_mem_size,
                           wstrb: dc.dcache_mem_wstrb,
                           addr:  dc.addr_dcache_mem,
                           wdata: dc.dout_dcache_mem};
                ic_q  <= '0;
                rc_q  <= '0;
            end else begin
                if (ic_inc_c) ic_q <= ic_q + CNT_W'(1);
                if (rc_inc_c) rc_q <= rc_q + CNT_W'(1);
            end
        end
    end

    // Line is cleared when a read is accepted and filled in return order.
    dcache_line_buf #(
        .offset_width (offset_width)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_c & ~dc.dcache_mem_wr),
        .we    (rc_inc_c),
        .widx  (rc_q[offset_width-1:0]),
        .wdata (dc.bus_rdata),
        .line  (line_c)
    );

    assign dc.din_mem_dcache = line_c;

endmodule
